mem_responder: RTL and testbench

Synchronous 256×8 memory that answers the CPU datapath's shared memory bus: it accepts an 8-bit `Address`, drives or samples the bidirectional `Data` bus, and signals completion. It also contains a byte-stream program loader, so a host can fill memory before the CPU runs. It is the responder end of the datapath's MAR/Data interface and replaces a purely combinational RAM model.

---
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: synchronous 2^ADDR_W x DATA_W memory that responds on the CPU
// shared memory bus. It also has a byte-stream loader so a host can fill the
// memory before the CPU runs.
//
// Ports:
//   clk, reset     - single clock; synchronous active-high reset
//   Address        - CPU address (from the MAR)
//   Data           - shared bidirectional bus; driven only while returning read data
//   rd / wr        - CPU read / write requests (write data sampled on the wr edge)
//   rd_valid       - one-cycle pulse while Data carries read data
//   wr_done        - one-cycle pulse after a write commits
//   prog_start     - begin a load at prog_base for prog_len bytes (0 = full depth)
//   prog_data/prog_valid/prog_ready - load byte handshake
//   busy           - load in progress; CPU requests are ignored
//   prog_done      - one-cycle pulse after the last load byte is written
//   checksum       - modulo-2^DATA_W sum of the bytes of the last load
module mem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              rd,
  input  logic              wr,
  output logic              rd_valid,
  output logic              wr_done,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              busy,
  output logic              prog_done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WDONE = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_ptr;
  // One extra bit so a length of 0 can stand for the full depth.
  logic [ADDR_W:0]     r_remain;
  logic [DATA_W-1:0]   r_checksum;
  logic                r_rd_valid;
  logic                r_wr_done;
  logic                r_prog_ready;
  logic                r_busy;
  logic                r_prog_done;

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // Single memory write port shared by CPU writes and the loader. Writes are
  // suppressed on a reset edge so a reset never commits a pending byte.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = Address;
    w_mem_wdata = Data;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (!prog_start && wr) begin
            w_mem_we = 1'b1;
          end
        end
        LOAD: begin
          if (prog_valid) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_ptr;
            w_mem_wdata = prog_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rdata      <= '0;
      r_ptr        <= '0;
      r_remain     <= '0;
      r_checksum   <= '0;
      r_rd_valid   <= 1'b0;
      r_wr_done    <= 1'b0;
      r_prog_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_prog_done  <= 1'b0;
    end else begin
      r_rd_valid  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_prog_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (prog_start) begin
            r_ptr        <= prog_base;
            r_remain     <= (prog_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, prog_len};
            r_checksum   <= '0;
            r_prog_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= LOAD;
          end else if (wr) begin
            r_wr_done <= 1'b1;
            r_state   <= WDONE;
          end else if (rd) begin
            r_rdata    <= r_mem[Address];
            r_rd_valid <= 1'b1;
            r_state    <= DRIVE;
          end
        end
        DRIVE: r_state <= IDLE;
        WDONE: r_state <= IDLE;
        LOAD: begin
          if (prog_valid) begin
            r_ptr      <= r_ptr + 1'b1;
            r_checksum <= r_checksum + prog_data;
            r_remain   <= r_remain - 1'b1;
            if (r_remain == (ADDR_W+1)'(1)) begin
              r_prog_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_prog_done  <= 1'b1;
              r_state      <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Data       = (r_state == DRIVE) ? r_rdata : 'z;
  assign rd_valid   = r_rd_valid;
  assign wr_done    = r_wr_done;
  assign prog_ready = r_prog_ready;
  assign busy       = r_busy;
  assign prog_done  = r_prog_done;
  assign checksum   = r_checksum;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Address;
  tri1  [7:0] Data;
  logic       rd;
  logic       wr;
  logic       rd_valid;
  logic       wr_done;
  logic       prog_start;
  logic [7:0] prog_base;
  logic [7:0] prog_len;
  logic [7:0] prog_data;
  logic       prog_valid;
  logic       prog_ready;
  logic       busy;
  logic       prog_done;
  logic [7:0] checksum;

  // Bench side of the bus; the tri1 pull makes a released bus read as all ones.
  logic       tb_drv;
  logic [7:0] tb_dat;
  assign Data = tb_drv ? tb_dat : 'z;

  mem_responder #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Data       (Data),
    .rd         (rd),
    .wr         (wr),
    .rd_valid   (rd_valid),
    .wr_done    (wr_done),
    .prog_start (prog_start),
    .prog_base  (prog_base),
    .prog_len   (prog_len),
    .prog_data  (prog_data),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .busy       (busy),
    .prog_done  (prog_done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  logic [7:0] rd_q [$];
  logic [7:0] ck_q [$];

  // Scoreboard: every read response and every load completion is compared
  // against the expectation queued when the stimulus was issued.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (rd_valid === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 Data=%h, required no read response", Data);
      end else begin
        exp = rd_q.pop_front();
        if (Data !== exp) begin
          errors++;
          $display("FAIL rd_data: Data=%h, required %h", Data, exp);
        end
      end
    end
    if (prog_done === 1'b1) begin
      checks++;
      if (ck_q.size() == 0) begin
        errors++;
        $display("FAIL prog_done_unexpected: prog_done=1 checksum=%h, required no completion", checksum);
      end else begin
        exp = ck_q.pop_front();
        if (checksum !== exp) begin
          errors++;
          $display("FAIL load_checksum: checksum=%h, required %h", checksum, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [7:0] addr);
    rd      = 1'b1;
    Address = addr;
    rd_q.push_back(model[addr]);
    tick();
    rd = 1'b0;
  endtask

  task automatic issue_write(input logic [7:0] addr, input logic [7:0] val);
    wr      = 1'b1;
    Address = addr;
    tb_drv  = 1'b1;
    tb_dat  = val;
    model[addr] = val;
    tick();
    wr     = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] base, input logic [7:0] len);
    prog_start = 1'b1;
    prog_base  = base;
    prog_len   = len;
    tick();
    prog_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({rd_valid, wr_done, prog_ready, busy, prog_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: rd_valid,wr_done,prog_ready,busy,prog_done=%b, required 00000",
               {rd_valid, wr_done, prog_ready, busy, prog_done});
    end
    checks++;
    if (checksum !== 8'h00) begin
      errors++;
      $display("FAIL reset_checksum: checksum=%h, required 00", checksum);
    end
    checks++;
    if (Data !== 8'hFF) begin
      errors++;
      $display("FAIL reset_bus: Data=%h, required released (reads FF)", Data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    issue_write(8'h10, 8'hA5);
    checks++;
    if (wr_done !== 1'b1) begin
      errors++;
      $display("FAIL wr_done_pulse: wr_done=%b, required 1", wr_done);
    end
    tick();
    checks++;
    if (wr_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_width: wr_done=%b, required 0", wr_done);
    end
    issue_read(8'h10);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency: rd_valid=%b, required 1", rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || Data !== 8'hFF) begin
      errors++;
      $display("FAIL rd_release: rd_valid=%b Data=%h, required 0 and FF", rd_valid, Data);
    end
  endtask

  task automatic test_load_wrap();
    logic [7:0] bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] ptr = 8'hFE;
    logic [7:0] sum = 8'h00;
    start_load(8'hFE, 8'd4);
    checks++;
    if (busy !== 1'b1 || prog_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_enter: busy=%b prog_ready=%b, required 1 1", busy, prog_ready);
    end
    for (int i = 0; i < 4; i++) begin
      prog_valid = 1'b1;
      prog_data  = bytes[i];
      model[ptr] = bytes[i];
      ptr        = ptr + 8'd1;
      sum        = sum + bytes[i];
      if (i == 3) ck_q.push_back(sum);
      tick();
    end
    prog_valid = 1'b0;
    checks++;
    if (prog_done !== 1'b1 || busy !== 1'b0 || prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_finish: prog_done=%b busy=%b prog_ready=%b, required 1 0 0",
               prog_done, busy, prog_ready);
    end
    checks++;
    if (checksum !== 8'h0A) begin
      errors++;
      $display("FAIL load_wrap_checksum: checksum=%h, required 0A", checksum);
    end
    tick();
    checks++;
    if (prog_done !== 1'b0) begin
      errors++;
      $display("FAIL prog_done_width: prog_done=%b, required 0", prog_done);
    end
    issue_read(8'hFE); tick();
    issue_read(8'hFF); tick();
    issue_read(8'h00); tick();
    issue_read(8'h01); tick();
  endtask

  task automatic test_load_gaps();
    logic [7:0] bytes [3] = '{8'hFF, 8'hFF, 8'h03};
    logic [7:0] ptr = 8'h80;
    logic [7:0] sum = 8'h00;
    int idx = 0;
    start_load(8'h80, 8'd3);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL gap_busy: cycle %0d busy=%b, required 1", c, busy);
      end
      if (c % 2 == 1) begin
        prog_valid = 1'b1;
        prog_data  = bytes[idx];
        model[ptr] = bytes[idx];
        ptr        = ptr + 8'd1;
        sum        = sum + bytes[idx];
        idx++;
        if (idx == 3) ck_q.push_back(sum);
      end else begin
        prog_valid = 1'b0;
        prog_data  = 8'h77;
      end
      tick();
    end
    prog_valid = 1'b0;
    checks++;
    if (checksum !== 8'h01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_result: checksum=%h busy=%b, required 01 0", checksum, busy);
    end
    tick();
    issue_read(8'h80); tick();
    issue_read(8'h81); tick();
    issue_read(8'h82); tick();
  endtask

  task automatic test_cpu_during_load();
    issue_write(8'h20, 8'hC3);
    tick();
    start_load(8'h90, 8'd2);
    wr      = 1'b1;
    Address = 8'h20;
    tb_drv  = 1'b1;
    tb_dat  = 8'h3C;
    tick();
    wr     = 1'b0;
    tb_drv = 1'b0;
    rd     = 1'b1;
    checks++;
    if (wr_done !== 1'b0) begin
      errors++;
      $display("FAIL load_wr_ignored: wr_done=%b, required 0", wr_done);
    end
    tick();
    rd = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || Data !== 8'hFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_rd_ignored: rd_valid=%b Data=%h busy=%b, required 0 FF 1",
               rd_valid, Data, busy);
    end
    tick();
    checks++;
    if (Data !== 8'hFF || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL load_bus_idle: Data=%h wr_done=%b, required FF 0", Data, wr_done);
    end
    prog_valid = 1'b1;
    prog_data  = 8'h12;
    model[8'h90] = 8'h12;
    tick();
    prog_data  = 8'h34;
    model[8'h91] = 8'h34;
    ck_q.push_back(8'h46);
    tick();
    prog_valid = 1'b0;
    tick();
    issue_read(8'h20); tick();
    issue_read(8'h91); tick();
  endtask

  task automatic test_simultaneous();
    wr      = 1'b1;
    rd      = 1'b1;
    Address = 8'h30;
    tb_drv  = 1'b1;
    tb_dat  = 8'h99;
    model[8'h30] = 8'h99;
    tick();
    wr     = 1'b0;
    rd     = 1'b0;
    tb_drv = 1'b0;
    checks++;
    if (wr_done !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_beats_rd: wr_done=%b rd_valid=%b, required 1 0", wr_done, rd_valid);
    end
    tick();
    issue_read(8'h30); tick();
    issue_write(8'h31, 8'h44); tick();
    prog_start = 1'b1;
    prog_base  = 8'hA0;
    prog_len   = 8'd1;
    wr         = 1'b1;
    Address    = 8'h31;
    tb_drv     = 1'b1;
    tb_dat     = 8'h55;
    tick();
    prog_start = 1'b0;
    wr         = 1'b0;
    tb_drv     = 1'b0;
    checks++;
    if (busy !== 1'b1 || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL start_beats_wr: busy=%b wr_done=%b, required 1 0", busy, wr_done);
    end
    prog_valid = 1'b1;
    prog_data  = 8'h7E;
    model[8'hA0] = 8'h7E;
    ck_q.push_back(8'h7E);
    tick();
    prog_valid = 1'b0;
    tick();
    issue_read(8'h31); tick();
    issue_read(8'hA0); tick();
  endtask

  task automatic test_reset_mid_op();
    start_load(8'h40, 8'd5);
    prog_valid = 1'b1;
    prog_data  = 8'h11;
    model[8'h40] = 8'h11;
    tick();
    prog_data  = 8'h22;
    model[8'h41] = 8'h22;
    tick();
    prog_valid = 1'b0;
    prog_data  = 8'h33;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || checksum !== 8'h00 || prog_ready !== 1'b0 || prog_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load: busy=%b checksum=%h prog_ready=%b prog_done=%b, required 0 00 0 0",
               busy, checksum, prog_ready, prog_done);
    end
    tick();
    tick();
    issue_read(8'h40); tick();
    issue_read(8'h41);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (Data !== 8'hFF || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drive: Data=%h rd_valid=%b, required FF 0", Data, rd_valid);
    end
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    Address    = 8'h00;
    rd         = 1'b0;
    wr         = 1'b0;
    prog_start = 1'b0;
    prog_base  = 8'h00;
    prog_len   = 8'h00;
    prog_data  = 8'h00;
    prog_valid = 1'b0;
    tb_drv     = 1'b0;
    tb_dat     = 8'h00;
    test_reset();
    test_write_read();
    test_load_wrap();
    test_load_gaps();
    test_cpu_during_load();
    test_simultaneous();
    test_reset_mid_op();
    tick();
    checks++;
    if (rd_q.size() != 0 || ck_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: reads pending=%0d loads pending=%0d, required 0 0",
               rd_q.size(), ck_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
